// File: rtl/load_store_unit.sv
// Load/store unit: byte, halfword and word accesses to a word-addressed data memory.
// Sub-word stores use read-modify-write. Define LSU_MISALIGN_CHECK_EN to flag misaligned accesses.
module load_store_unit (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        signext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] rdata,
  output logic [31:0] memaddress,
  output logic [31:0] memwritedata,
  output logic        memwrite,
  output logic        memread,
  input  logic [31:0] memreaddata
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic        we_q, signext_q;
  logic [1:0]  size_q, lane_q;
  logic [15:0] wdata_q;
  logic        mis_in, is_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merge_val;

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis_in = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
                  (size == 2'b11);
`else
  assign mis_in = 1'b0;
`endif
  // size=11 only reaches the datapath when checking is off, where it acts as a word
  assign is_word = size[1];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (mis_in)             state_next = DONE;
          else if (we && is_word) state_next = WRITE;
          else                    state_next = READ;
        end
      end
      READ:    state_next = WAIT;
      WAIT:    state_next = we_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != IDLE);
      done     <= (state_next == DONE);
      memread  <= (state_next == READ);
      memwrite <= (state_next == WRITE);
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_reg;
  // Only a misaligned request jumps straight from IDLE to DONE
  always_ff @(posedge clock) begin
    if (!resetn) misalign_reg <= 1'b0;
    else         misalign_reg <= (state == IDLE) && req && mis_in;
  end
  assign misalign = misalign_reg;
`else
  assign misalign = 1'b0;
`endif

  // Lane extraction for loads and lane merge for sub-word stores, both from the read word
  always_comb begin
    load_val  = memreaddata;
    merge_val = memreaddata;
    byte_sel  = memreaddata[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? memreaddata[31:16] : memreaddata[15:0];
    case (size_q)
      2'b00: begin
        load_val = {{24{signext_q & byte_sel[7]}}, byte_sel};
        merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{signext_q & half_sel[15]}}, half_sel};
        if (lane_q[1]) merge_val[31:16] = wdata_q;
        else           merge_val[15:0]  = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      we_q         <= 1'b0;
      signext_q    <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      rdata        <= 32'h0;
      memaddress   <= 32'h0;
      memwritedata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q       <= we;
            signext_q  <= signext;
            size_q     <= size;
            lane_q     <= addr[1:0];
            wdata_q    <= wdata[15:0];
            memaddress <= {addr[31:2], 2'b00};
            if (we && is_word) memwritedata <= wdata;
          end
        end
        WAIT: begin
          if (we_q) memwritedata <= merge_val;
          else      rdata        <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array memory model.
// Expectations follow LSU_MISALIGN_CHECK_EN when it is defined for the build.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0, we = 1'b0, signext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busy, done, misalign, memwrite, memread;
  logic [31:0] rdata, memaddress, memwritedata;
  logic [31:0] memreaddata = 32'h0;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  load_store_unit dut (
    .clock(clock), .resetn(resetn), .req(req), .we(we), .size(size), .signext(signext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
    .rdata(rdata), .memaddress(memaddress), .memwritedata(memwritedata),
    .memwrite(memwrite), .memread(memread), .memreaddata(memreaddata)
  );

  always #5 clock = ~clock;

  // Data memory: read word appears one edge after the memread edge
  always @(posedge clock) begin
    if (pre_we) env_mem[pre_idx] <= pre_val;
    else if (memwrite) env_mem[memaddress[9:2]] <= memwritedata;
    if (memread) memreaddata <= env_mem[memaddress[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clock);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clock);
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd, input int poke_cycle);
    logic        mis, got, mis_at_done;
    int          eff, shift, lat, exp_rd, exp_wr, n, nrd, nwr, bad_addr, both, mis_out, busy_bad;
    logic [63:0] mask64;
    logic [31:0] mask, old, v;
    logic [7:0]  idx;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd3);
`else
    mis = 1'b0;
`endif
    eff    = (sz == 2'd3) ? 2 : int'(sz);
    idx    = a[9:2];
    old    = ref_mem[idx];
    shift  = (eff == 0) ? 8 * int'(a[1:0]) : (eff == 1) ? (a[1] ? 16 : 0) : 0;
    mask64 = (64'd1 << (8 * (1 << eff))) - 64'd1;
    mask   = mask64[31:0];
    if (mis) begin
      lat = 2; exp_rd = 0; exp_wr = 0;
    end else if (w) begin
      exp_wr = 1; exp_rd = (eff != 2) ? 1 : 0; lat = (eff == 2) ? 3 : 5;
      ref_mem[idx] = (old & ~(mask << shift)) | ((wd & mask) << shift);
    end else begin
      exp_rd = 1; exp_wr = 0; lat = 4;
      v = (old >> shift) & mask;
      if (sx && eff != 2 && ((v >> (8 * (1 << eff) - 1)) & 32'd1) != 0) v = v | ~mask;
      ref_rdata = v;
    end

    @(negedge clock);
    we = w; size = sz; signext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clock);
    n = 1; got = 1'b0; mis_at_done = 1'b0;
    nrd = 0; nwr = 0; bad_addr = 0; both = 0; mis_out = 0; busy_bad = 0;
    while (!got && n < 12) begin
      @(negedge clock);
      n++;
      req = (n == poke_cycle);
      if (memread) nrd++;
      if (memwrite) nwr++;
      if ((memread || memwrite) && memaddress !== {a[31:2], 2'b00}) bad_addr++;
      if (memread && memwrite) both++;
      if (misalign && !done) mis_out++;
      if (!busy) busy_bad++;
      if (done) begin got = 1'b1; mis_at_done = misalign; end
    end
    req = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(lat));
    check("misalign", 32'(mis_at_done), 32'(mis));
    check("rdata", rdata, ref_rdata);
    check("memread_cnt", 32'(nrd), 32'(exp_rd));
    check("memwrite_cnt", 32'(nwr), 32'(exp_wr));
    check("strobe_addr", 32'(bad_addr), 32'd0);
    check("rd_wr_overlap", 32'(both), 32'd0);
    check("misalign_outside_done", 32'(mis_out), 32'd0);
    check("busy_during", 32'(busy_bad), 32'd0);
    check("mem_word", env_mem[idx], ref_mem[idx]);
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    $display("txn we=%0d size=%0d sx=%0d addr=%h wdata=%h lat=%0d rdata=%h mis=%0d",
             w, sz, sx, a, wd, n, rdata, mis_at_done);
  endtask

  task automatic reset_mid_store(input logic [31:0] a);
    int ndone;
    @(negedge clock);
    we = 1'b1; size = 2'b10; signext = 1'b0; addr = a; wdata = ref_mem[a[9:2]]; req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    check("rst_in_write", 32'(memwrite), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    check("rst_memwrite", 32'(memwrite), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memaddress", memaddress, 32'h0);
    check("rst_memwritedata", memwritedata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    resetn = 1'b1;
    ref_rdata = 32'h0;
    ndone = 0;
    repeat (5) begin
      @(negedge clock);
      if (done || memwrite) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    $display("txn reset during word store addr=%h", a);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    check("reset_memread", 32'(memread), 32'd0);
    check("reset_memwrite", 32'(memwrite), 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_memaddress", memaddress, 32'h0);
    check("reset_memwritedata", memwritedata, 32'h0);
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    resetn = 1'b1;
    @(negedge clock);

    run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("word_roundtrip", rdata, 32'hDEADBEEF);

    poke(8'h08, 32'h12F45678);
    run_access(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 0);
    check("byte_signed", rdata, 32'hFFFFFFF4);
    run_access(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 0);
    check("byte_unsigned", rdata, 32'h000000F4);

    poke(8'h0C, 32'hAAAABBBB);
    run_access(1'b1, 2'b01, 1'b0, 32'h32, 32'h00001234, 0);
    check("half_rmw", env_mem[8'h0C], 32'h1234BBBB);

    run_access(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 0);
    run_access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 0);
    run_access(1'b1, 2'b11, 1'b0, 32'h50, 32'hCAFEF00D, 0);
    run_access(1'b1, 2'b00, 1'b0, 32'h57, 32'h000000A5, 0);
    run_access(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 3);

    reset_mid_store(32'h70);
    run_access(1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 0);

    for (int t = 0; t < 150; t++) begin
      run_access(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 1023)),
                 $urandom, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL expose these ports, clock and reset first: clock  in  1  single system clock, all state changes on posedge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 req  in  1  CPU access request, sampled only in IDLE; we  in  1  1=store, 0=load.
REQ-004 size  in  2  00=byte, 01=halfword, 10=word, 11=illegal; signext  in  1  1=sign-extend sub-word loads, 0=zero-extend.
REQ-005 addr  in  32  byte address; wdata  in  32  store data, right-justified for sub-word stores.
REQ-006 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse; misalign  out  1  qualifies done as an error.
REQ-007 rdata  out  32  load result, held until the next load completes.
REQ-008 memaddress  out  32  word address to data memory; memwritedata  out  32  word to write; memwrite  out  1  and memread  out  1  data memory strobes.
REQ-009 memreaddata  in  32  data memory read word, valid on the second posedge after the memread cycle.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, READ, WAIT, WRITE and DONE, with all outputs registered.
REQ-011 In IDLE with req=1, the block SHALL latch we, size, signext, addr and wdata on the same edge.
REQ-012 It SHALL then move to DONE with misalign=1 when the access is misaligned; otherwise a word store SHALL move to WRITE, and any load or sub-word store SHALL move to READ.
REQ-013 Misaligned means size=01 with addr[0]=1, size=10 with addr[1:0]!=00, or size=11; a misaligned access SHALL NOT assert memread or memwrite.
REQ-014 memaddress SHALL equal {addr[31:2],2'b00} for the whole access.
REQ-015 READ SHALL last one cycle with memread=1, and WAIT SHALL last one cycle with memread=0.
REQ-016 On the edge that leaves WAIT, memreaddata SHALL be captured; a load then goes to DONE and a sub-word store goes to WRITE.
REQ-017 Byte lanes SHALL be little-endian: a byte uses bits [8k+7:8k] with k=addr[1:0], and a halfword uses bits [31:16] when addr[1]=1, otherwise bits [15:0].
REQ-018 A load SHALL write the selected lane to rdata, extended to 32 bits by signext; a word load SHALL write the full word.
REQ-019 WRITE SHALL last one cycle with memwrite=1, then go to DONE.
REQ-020 For a word store, memwritedata SHALL equal wdata; for a sub-word store, it SHALL be the captured word with only the selected lane replaced by wdata[7:0] or wdata[15:0].
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE; misalign SHALL be low outside DONE.
REQ-022 Latency, counted in cycles from the accepting edge to the done cycle, SHALL be: 3 for a word store, 4 for a load, 5 for a sub-word store, 2 for a misaligned access.
REQ-023 req while busy=1 SHALL be ignored; no request is queued.
REQ-024 req held high through DONE SHALL start a new access on the edge after DONE, while in IDLE.
REQ-025 memread and memwrite SHALL never be high in the same cycle.

Reset
REQ-026 With resetn=0 at a posedge, the state SHALL become IDLE, and busy, done, misalign, memread and memwrite SHALL become 0.
REQ-027 With resetn=0 at a posedge, memaddress, memwritedata and rdata SHALL become 32'h0.
REQ-028 Reset mid-operation, including in WRITE, SHALL abort the access; memwrite SHALL be low from the next cycle, and no done SHALL be produced.

Configuration
REQ-029 With LSU_MISALIGN_CHECK_EN defined, misaligned accesses SHALL behave as in REQ-012 and REQ-013.
REQ-030 Without LSU_MISALIGN_CHECK_EN, the misalign output SHALL be tied to 0.
REQ-031 Without LSU_MISALIGN_CHECK_EN, halfword accesses SHALL ignore addr[0], word accesses SHALL ignore addr[1:0], and size=11 SHALL be treated as word.

Verification
REQ-032 Word store then load: store addr=0x10, wdata=0xDEADBEEF; then load word at addr=0x10 -> one memwrite pulse to 0x10, rdata=0xDEADBEEF, done 4 cycles after load accept.
REQ-033 Signed byte load: memory word 0x12F4_5678 at 0x20; load byte addr=0x22, signext=1 -> rdata=0xFFFFFFF4; the same with signext=0 -> rdata=0x000000F4.
REQ-034 Halfword read-modify-write: memory word 0xAAAA_BBBB; store half addr=0x32, wdata=0x00001234 -> memwritedata=0x1234_BBBB, done 5 cycles after accept.
REQ-035 Misaligned access with macro defined: load word addr=0x41 -> done=1 and misalign=1 two cycles after accept, no memread or memwrite, rdata unchanged.
REQ-036 Same access without macro: load word addr=0x41 -> reads word 0x40, misalign=0.
REQ-037 Reset mid-store: resetn=0 during WRITE -> memwrite=0 on the next cycle, busy=0, no done pulse.
REQ-038 req asserted while busy: req pulsed in WAIT -> ignored, exactly one done pulse.
